// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control feeding the instruction ROM of the single-cycle core.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 16,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] instr_count_o,
  output logic [31:0] stall_count_o
);

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

  // One bit wider than the PC so a large IMEM_DEPTH cannot overflow the limit.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) << 2;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        target_bad;
  logic        in_run;

  assign in_run   = (state_reg == RUN);
  assign pc_plus4 = pc_reg + 32'd4;

  always_comb begin
    target = pc_plus4;
    if (jump_i)
      target = jump_target_i;
    else if (branch_taken_i)
      target = branch_target_i;
    target_bad = (target[1:0] != 2'b00) || ({1'b0, target} >= PC_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Halt is checked before the redirect so an ecall always wins over a jump/branch.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        if (!stall_i) begin
          if (imem_data_i == HALT_INSTR)
            state_next = HALT;
          else if (target_bad)
            state_next = FAULT;
          else
            pc_next = target;
        end
      end
      default: begin
        state_next = state_reg;
        pc_next    = pc_reg;
      end
    endcase
  end

  assign imem_addr_o   = {2'b00, pc_reg[31:2]};
  assign pc_o          = pc_reg;
  assign pc_plus4_o    = pc_plus4;
  assign instr_valid_o = in_run;
  assign instr_o       = in_run ? imem_data_i : NOP_INSTR;
  assign halted_o      = (state_reg == HALT);
  assign fault_o       = (state_reg == FAULT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_count_reg;
  logic [31:0] stall_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_reg <= 32'h0;
      stall_count_reg <= 32'h0;
    end else if (in_run) begin
      if (!stall_i && (instr_count_reg != 32'hFFFF_FFFF))
        instr_count_reg <= instr_count_reg + 32'd1;
      if (stall_i && (stall_count_reg != 32'hFFFF_FFFF))
        stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign instr_count_o = instr_count_reg;
  assign stall_count_o = stall_count_reg;
`else
  assign instr_count_o = 32'h0;
  assign stall_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues the expected fetch of each RUN cycle,
// a negedge monitor pops and compares whenever instr_valid_o is presented.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_0073;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall, jump, branch;
  logic [31:0] jump_target, branch_target;
  logic [31:0] imem_addr, imem_data, instr;
  logic        instr_valid, halted, fault;
  logic [31:0] pc, pc_plus4, instr_count, stall_count;

  logic [31:0] rom [16];
  logic [63:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall),
    .jump_i         (jump),
    .jump_target_i  (jump_target),
    .branch_taken_i (branch),
    .branch_target_i(branch_target),
    .imem_addr_o    (imem_addr),
    .imem_data_i    (imem_data),
    .instr_o        (instr),
    .instr_valid_o  (instr_valid),
    .pc_o           (pc),
    .pc_plus4_o     (pc_plus4),
    .halted_o       (halted),
    .fault_o        (fault),
    .instr_count_o  (instr_count),
    .stall_count_o  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'd16) ? rom[imem_addr[3:0]] : NOP;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per presented fetch; a queued entry with no valid is also an error.
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'b0, instr_valid}, 32'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          $display("fetch pc=%h instr=%h (expected pc=%h instr=%h)", pc, instr, e[63:32], e[31:0]);
          chk("fetch_pc", pc, e[63:32]);
          chk("fetch_instr", instr, e[31:0]);
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_valid", {31'b0, instr_valid}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic [31:0] exp_pc, input logic st, input logic j,
                      input logic [31:0] jt, input logic b, input logic [31:0] bt);
    stall = st; jump = j; jump_target = jt; branch = b; branch_target = bt;
    exp_q.push_back({exp_pc, rom[exp_pc[5:2]]});
    @(posedge clk); #1;
    stall = 1'b0; jump = 1'b0; branch = 1'b0;
  endtask

  task automatic idle_jump(input int n);
    jump = 1'b1; jump_target = 32'h20;
    repeat (n) begin @(posedge clk); #1; end
    jump = 1'b0;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_icount", instr_count, 32'd0);
    chk("rst_scount", stall_count, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("boot_valid", {31'b0, instr_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1;
    stall = 0; jump = 0; branch = 0; jump_target = 0; branch_target = 0;
    for (int i = 0; i < 16; i++) rom[i] = NOP;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("reset_pc", pc, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_valid", {31'b0, instr_valid}, 32'd0);
    chk("reset_instr", instr, NOP);
    chk("reset_halted", {31'b0, halted}, 32'd0);
    chk("reset_fault", {31'b0, fault}, 32'd0);
    chk("reset_icount", instr_count, 32'd0);
    chk("reset_scount", stall_count, 32'd0);
    chk("reset_plus4", pc_plus4, 32'h4);
    rst_n = 1'b1;
    chk("boot_valid", {31'b0, instr_valid}, 32'd0);
    chk("boot_addr", imem_addr, 32'h0);
    @(posedge clk); #1;

    // Sequential fetch, then stall swallowing a held jump
    step(32'h0, 0, 0, 0, 0, 0);
    step(32'h4, 0, 0, 0, 0, 0);
    repeat (3) step(32'h8, 1, 1, 32'h20, 0, 0);
    step(32'h8, 0, 1, 32'h20, 0, 0);
    step(32'h20, 0, 0, 0, 0, 0);
    chk("pc_after_jump", pc, 32'h24);
    chk("addr_after_jump", imem_addr, 32'h9);
    chk("plus4_after_jump", pc_plus4, 32'h28);
    chk("stall_count", stall_count, PERF ? 32'd3 : 32'd0);
    chk("instr_count", instr_count, PERF ? 32'd4 : 32'd0);

    // Jump beats branch, branch alone, then run off the end of the ROM
    step(32'h24, 0, 1, 32'h10, 1, 32'h30);
    step(32'h10, 0, 0, 0, 1, 32'h30);
    step(32'h30, 0, 0, 0, 0, 0);
    step(32'h34, 0, 0, 0, 0, 0);
    step(32'h38, 0, 0, 0, 0, 0);
    step(32'h3C, 0, 0, 0, 0, 0);
    chk("runoff_fault", {31'b0, fault}, 32'd1);
    chk("runoff_pc", pc, 32'h3C);
    chk("runoff_valid", {31'b0, instr_valid}, 32'd0);
    chk("runoff_halted", {31'b0, halted}, 32'd0);
    idle_jump(2);
    chk("fault_sticky_pc", pc, 32'h3C);
    chk("fault_sticky", {31'b0, fault}, 32'd1);
    chk("fault_icount", instr_count, PERF ? 32'd10 : 32'd0);

    // Halt on ecall at 0xC
    rom[3] = HALT;
    restart();
    step(32'h0, 0, 0, 0, 0, 0);
    step(32'h4, 0, 0, 0, 0, 0);
    step(32'h8, 0, 0, 0, 0, 0);
    step(32'hC, 0, 1, 32'h20, 0, 0);
    chk("halt_flag", {31'b0, halted}, 32'd1);
    chk("halt_pc", pc, 32'hC);
    chk("halt_valid", {31'b0, instr_valid}, 32'd0);
    chk("halt_instr_nop", instr, NOP);
    chk("halt_fault", {31'b0, fault}, 32'd0);
    idle_jump(2);
    chk("halt_frozen_pc", pc, 32'hC);
    chk("halt_sticky", {31'b0, halted}, 32'd1);
    chk("halt_icount", instr_count, PERF ? 32'd4 : 32'd0);

    // Misaligned branch target
    rom[3] = NOP;
    restart();
    step(32'h0, 0, 0, 0, 1, 32'h22);
    chk("misalign_fault", {31'b0, fault}, 32'd1);
    chk("misalign_pc", pc, 32'h0);

    // Asynchronous reset between clock edges
    restart();
    step(32'h0, 0, 0, 0, 0, 0);
    step(32'h4, 0, 0, 0, 0, 0);
    step(32'h8, 0, 0, 0, 0, 0);
    step(32'hC, 0, 0, 0, 0, 0);
    step(32'h10, 0, 0, 0, 0, 0);
    chk("pre_async_pc", pc, 32'h14);
    chk("pre_async_icount", instr_count, PERF ? 32'd5 : 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_valid", {31'b0, instr_valid}, 32'd0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_instr", instr, NOP);
    chk("async_icount", instr_count, 32'd0);
    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
